// File: rtl/ipv6_burst_packetiser.sv
// Buffers sensor bytes in a FIFO and frames every PAYLOAD_LEN bytes as a
// compressed IPv6 packet: [DISPATCH][NODE_ID][seq][len][payload...][XOR chk],
// streamed one byte per send strobe and paced by radio_busy.
module ipv6_burst_packetiser #(
  parameter int unsigned PAYLOAD_LEN = 4,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [7:0]  DISPATCH    = 8'h41,
  parameter logic [7:0]  NODE_ID     = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [7:0] tx_data,
  output logic       send,
  input  logic       radio_busy,
  output logic       packet_valid,
  output logic [7:0] seq_num,
  output logic       overflow
);

  localparam int unsigned TOTAL = PAYLOAD_LEN + 5;
  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop;
  logic [IW-1:0] idx, idx_n;
  logic [7:0]    chk, chk_n, cur_byte, tx_data_n, seq_n;
  logic          send_n, pv_n, is_payload;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign data_ready = !full;
  assign push       = data_valid && !full;
  assign is_payload = (idx >= IW'(4)) && (idx < IW'(TOTAL - 1));

  // Byte of the packet at position idx; the final position carries the running XOR.
  always_comb begin
    cur_byte = chk;
    if (idx == IW'(0))             cur_byte = DISPATCH;
    else if (idx == IW'(1))        cur_byte = NODE_ID;
    else if (idx == IW'(2))        cur_byte = seq_num;
    else if (idx == IW'(3))        cur_byte = 8'(PAYLOAD_LEN);
    else if (idx < IW'(TOTAL - 1)) cur_byte = mem[rd_ptr];
  end

  // Next-state and next-output logic; EMIT and GAP alternate so sends never abut.
  always_comb begin
    state_n   = state;
    send_n    = 1'b0;
    tx_data_n = tx_data;
    idx_n     = idx;
    chk_n     = chk;
    pv_n      = packet_valid;
    seq_n     = seq_num;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count >= CW'(PAYLOAD_LEN)) begin
          state_n = EMIT;
          idx_n   = '0;
          chk_n   = '0;
          pv_n    = 1'b1;
        end
      end
      EMIT: begin
        if (!radio_busy) begin
          send_n    = 1'b1;
          tx_data_n = cur_byte;
          chk_n     = chk ^ cur_byte;
          idx_n     = idx + IW'(1);
          pop       = is_payload;
          state_n   = GAP;
        end
      end
      GAP: begin
        if (idx == IW'(TOTAL)) begin
          state_n = IDLE;
          pv_n    = 1'b0;
          seq_n   = seq_num + 8'd1;
        end else begin
          state_n = EMIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Packet datapath registers driven by the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send         <= 1'b0;
      tx_data      <= '0;
      idx          <= '0;
      chk          <= '0;
      packet_valid <= 1'b0;
      seq_num      <= '0;
    end else begin
      send         <= send_n;
      tx_data      <= tx_data_n;
      idx          <= idx_n;
      chk          <= chk_n;
      packet_valid <= pv_n;
      seq_num      <= seq_n;
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // FIFO pointers, occupancy and overflow pulse for writes refused while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= data_valid && full;
      if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_ipv6_burst_packetiser.sv
// Directed self-checking bench for ipv6_burst_packetiser with default parameters.
module tb_ipv6_burst_packetiser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] tx_data;
  logic       send;
  logic       radio_busy;
  logic       packet_valid;
  logic [7:0] seq_num;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q[$];
  int         tq[$];
  int         cyc = 0;
  int         pv_cycles = 0;
  int         ovf_pulses = 0;
  int         dbl_send = 0;
  logic       prev_send = 1'b0;

  ipv6_burst_packetiser #(
    .PAYLOAD_LEN(4),
    .FIFO_DEPTH (8),
    .DISPATCH   (8'h41),
    .NODE_ID    (8'h01)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .tx_data     (tx_data),
    .send        (send),
    .radio_busy  (radio_busy),
    .packet_valid(packet_valid),
    .seq_num     (seq_num),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Records every transmitted byte with its cycle number, plus pulse statistics.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (send) begin
      q.push_back(tx_data);
      tq.push_back(cyc);
      if (prev_send) dbl_send++;
    end
    prev_send = send;
    if (packet_valid) pv_cycles++;
    if (overflow) ovf_pulses++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [71:0] make_pkt(input logic [7:0] s, input logic [31:0] pl);
    logic [63:0] h;
    logic [7:0]  c;
    h = {8'h41, 8'h01, s, 8'h04, pl};
    c = '0;
    for (int i = 0; i < 8; i++) c ^= h[8*i +: 8];
    return {h, c};
  endfunction

  task automatic push(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int g = 0;
    while (q.size() < n && g < 300) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (q.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d bytes, expected %0d", tag, q.size(), n);
    end
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (packet_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (packet_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: packet_valid=%b expected 0", tag, packet_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({send, tx_data, packet_valid, seq_num, overflow, data_ready} !== {1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: send=%b tx=%02h pv=%b seq=%02h ovf=%b rdy=%b expected 0 00 0 00 0 1",
               send, tx_data, packet_valid, seq_num, overflow, data_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_packet;
    logic [71:0] exp;
    q.delete(); tq.delete();
    pv_cycles = 0;
    push(8'hAB); push(8'hCD); push(8'hEF); push(8'h01);
    n_checks++;
    if (packet_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_pv_early: got %b expected 0", packet_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({packet_valid, send} !== 2'b10) begin
      n_fail++; $display("FAIL basic_pv_latency: pv,send=%b%b expected 10", packet_valid, send);
    end
    @(negedge clk);
    n_checks++;
    if ({send, tx_data} !== {1'b1, 8'h41}) begin
      n_fail++; $display("FAIL basic_first_send: send=%b tx=%02h expected 1 41", send, tx_data);
    end
    wait_bytes(9, "basic");
    exp = 72'h41_01_00_04_AB_CD_EF_01_CC;
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (q[i] !== exp[71-8*i -: 8]) begin
        n_fail++; $display("FAIL basic_byte%0d: got %02h expected %02h", i, q[i], exp[71-8*i -: 8]);
      end
    end
    wait_idle("basic");
    n_checks++;
    if (pv_cycles !== 18) begin
      n_fail++; $display("FAIL basic_pv_span: got %0d cycles expected 18", pv_cycles);
    end
    n_checks++;
    if (seq_num !== 8'h01) begin
      n_fail++; $display("FAIL basic_seq: got %02h expected 01", seq_num);
    end
  endtask

  task automatic test_threshold;
    logic [71:0] exp;
    int g;
    q.delete();
    push(8'h11); push(8'h22); push(8'h33);
    pv_cycles = 0;
    repeat (50) @(negedge clk);
    n_checks++;
    if (pv_cycles !== 0 || q.size() !== 0) begin
      n_fail++; $display("FAIL threshold_no_packet: pv cycles %0d bytes %0d expected 0 0", pv_cycles, q.size());
    end
    push(8'h44);
    g = 0;
    while (!packet_valid && g < 2) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (packet_valid !== 1'b1) begin
      n_fail++; $display("FAIL threshold_trigger: pv=%b expected 1 within 2 cycles", packet_valid);
    end
    wait_bytes(9, "threshold");
    exp = make_pkt(8'h01, 32'h11223344);
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (q[i] !== exp[71-8*i -: 8]) begin
        n_fail++; $display("FAIL threshold_byte%0d: got %02h expected %02h", i, q[i], exp[71-8*i -: 8]);
      end
    end
    wait_idle("threshold");
    n_checks++;
    if (seq_num !== 8'h02) begin
      n_fail++; $display("FAIL threshold_seq: got %02h expected 02", seq_num);
    end
  endtask

  task automatic test_radio_busy;
    logic [71:0] exp;
    int sends;
    q.delete();
    push(8'h5A); push(8'hA5); push(8'h3C); push(8'hC3);
    wait_bytes(2, "busy_pre");
    radio_busy = 1'b1;
    sends = 0;
    repeat (7) begin
      @(negedge clk);
      if (send) sends++;
    end
    n_checks++;
    if (sends !== 0 || q.size() !== 2) begin
      n_fail++; $display("FAIL busy_hold: sends %0d bytes %0d expected 0 2", sends, q.size());
    end
    radio_busy = 1'b0;
    wait_bytes(9, "busy");
    exp = make_pkt(8'h02, 32'h5AA53CC3);
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (q[i] !== exp[71-8*i -: 8]) begin
        n_fail++; $display("FAIL busy_byte%0d: got %02h expected %02h", i, q[i], exp[71-8*i -: 8]);
      end
    end
    wait_idle("busy");
    repeat (5) @(negedge clk);
    n_checks++;
    if (q.size() !== 9 || seq_num !== 8'h03) begin
      n_fail++; $display("FAIL busy_count_seq: bytes %0d seq %02h expected 9 03", q.size(), seq_num);
    end
  endtask

  task automatic test_overflow;
    logic [143:0] exp;
    q.delete();
    ovf_pulses = 0;
    radio_busy = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    n_checks++;
    if (data_ready !== 1'b0) begin
      n_fail++; $display("FAIL overflow_ready_full: got %b expected 0", data_ready);
    end
    push(8'h09);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ovf_pulses !== 1) begin
      n_fail++; $display("FAIL overflow_pulse: got %0d pulse cycles expected 1", ovf_pulses);
    end
    n_checks++;
    if ({data_ready, packet_valid, q.size() == 0} !== 3'b011) begin
      n_fail++; $display("FAIL overflow_held: rdy=%b pv=%b bytes=%0d expected 0 1 0", data_ready, packet_valid, q.size());
    end
    radio_busy = 1'b0;
    wait_bytes(18, "overflow");
    exp = {make_pkt(8'h03, 32'h01020304), make_pkt(8'h04, 32'h05060708)};
    for (int i = 0; i < 18; i++) begin
      n_checks++;
      if (q[i] !== exp[143-8*i -: 8]) begin
        n_fail++; $display("FAIL overflow_byte%0d: got %02h expected %02h", i, q[i], exp[143-8*i -: 8]);
      end
    end
    wait_idle("overflow");
    repeat (20) @(negedge clk);
    n_checks++;
    if (q.size() !== 18 || data_ready !== 1'b1 || seq_num !== 8'h05) begin
      n_fail++; $display("FAIL overflow_after: bytes %0d rdy %b seq %02h expected 18 1 05", q.size(), data_ready, seq_num);
    end
  endtask

  task automatic test_reset_mid_packet;
    q.delete();
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    wait_bytes(6, "midrst_pre");
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({send, tx_data, packet_valid, seq_num, overflow, data_ready} !== {1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_async: send=%b tx=%02h pv=%b seq=%02h ovf=%b rdy=%b expected 0 00 0 00 0 1",
               send, tx_data, packet_valid, seq_num, overflow, data_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if (q.size() !== 6 || packet_valid !== 1'b0 || seq_num !== 8'h00) begin
      n_fail++; $display("FAIL midrst_after: bytes %0d pv %b seq %02h expected 6 0 00", q.size(), packet_valid, seq_num);
    end
  endtask

  task automatic test_back_to_back;
    logic [143:0] exp;
    q.delete(); tq.delete();
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    wait_bytes(18, "b2b");
    exp = {make_pkt(8'h00, 32'h10111213), make_pkt(8'h01, 32'h14151617)};
    for (int i = 0; i < 18; i++) begin
      n_checks++;
      if (q[i] !== exp[143-8*i -: 8]) begin
        n_fail++; $display("FAIL b2b_byte%0d: got %02h expected %02h", i, q[i], exp[143-8*i -: 8]);
      end
    end
    n_checks++;
    if (tq[9] - tq[0] !== 19) begin
      n_fail++; $display("FAIL b2b_gap: second packet started %0d cycles after first, expected 19", tq[9] - tq[0]);
    end
    wait_idle("b2b");
    n_checks++;
    if (seq_num !== 8'h02) begin
      n_fail++; $display("FAIL b2b_seq: got %02h expected 02", seq_num);
    end
  endtask

  task automatic test_seq_wrap;
    logic [71:0] exp;
    logic [7:0]  s;
    int g;
    for (int p = 0; p < 260 && seq_num != 8'hFF; p++) begin
      s = seq_num;
      for (int i = 0; i < 4; i++) push(8'(p + i));
      g = 0;
      while (seq_num == s && g < 100) begin
        @(negedge clk);
        g++;
      end
    end
    n_checks++;
    if (seq_num !== 8'hFF) begin
      n_fail++; $display("FAIL wrap_reach_ff: got %02h expected ff", seq_num);
    end
    q.delete();
    push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF);
    wait_bytes(9, "wrap_ff");
    exp = make_pkt(8'hFF, 32'hDEADBEEF);
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (q[i] !== exp[71-8*i -: 8]) begin
        n_fail++; $display("FAIL wrap_ff_byte%0d: got %02h expected %02h", i, q[i], exp[71-8*i -: 8]);
      end
    end
    wait_idle("wrap_ff");
    n_checks++;
    if (seq_num !== 8'h00) begin
      n_fail++; $display("FAIL wrap_seq_zero: got %02h expected 00", seq_num);
    end
    q.delete();
    push(8'h12); push(8'h34); push(8'h56); push(8'h78);
    wait_bytes(9, "wrap_00");
    exp = make_pkt(8'h00, 32'h12345678);
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (q[i] !== exp[71-8*i -: 8]) begin
        n_fail++; $display("FAIL wrap_00_byte%0d: got %02h expected %02h", i, q[i], exp[71-8*i -: 8]);
      end
    end
    wait_idle("wrap_00");
    n_checks++;
    if (seq_num !== 8'h01) begin
      n_fail++; $display("FAIL wrap_seq_one: got %02h expected 01", seq_num);
    end
  endtask

  initial begin
    rst        = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
    radio_busy = 1'b0;
    test_reset;
    test_basic_packet;
    test_threshold;
    test_radio_busy;
    test_overflow;
    test_reset_mid_packet;
    test_back_to_back;
    test_seq_wrap;
    n_checks++;
    if (dbl_send !== 0) begin
      n_fail++; $display("FAIL send_pacing: %0d consecutive-cycle sends, expected 0", dbl_send);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
